// File: rtl/spi_frame_tx_if.sv
// rtl/spi_frame_tx_if.sv - filter-bank sample bus feeding the SPI frame transmitter
interface spi_frame_tx_if #(
  parameter int DATA_W = 16,
  parameter int NUM_CH = 2
);
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [NUM_CH-1:0]        ch_valid;

  modport master (output ch_data, output ch_valid);
  modport slave  (input  ch_data, input  ch_valid);
endinterface

// File: rtl/spi_frame_tx.sv
// rtl/spi_frame_tx.sv - multi-channel framed SPI slave transmitter (mode 0) for filter outputs
// Optional CRC-8 trailer byte: define SPI_FRAME_CRC_EN
module spi_frame_tx #(
  parameter int   DATA_W   = 16,
  parameter int   NUM_CH   = 2,
  parameter logic IDLE_BIT = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  spi_frame_tx_if.slave ch,
  input  logic          rpi_sck,
  input  logic          rpi_cs,
  output logic          rpi_miso,
  output logic          busy,
  output logic          frame_done,
  output logic          overrun
);

  localparam int BODY_BITS = 8 + NUM_CH * DATA_W;
`ifdef SPI_FRAME_CRC_EN
  localparam int CRC_BITS = 8;
`else
  localparam int CRC_BITS = 0;
`endif
  localparam int FRAME_BITS = BODY_BITS + CRC_BITS;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [1:0] sck_sync_q;
  logic       sck_prev_q;
  logic [1:0] cs_sync_q;
  logic       cs_prev_q;

  logic [NUM_CH*DATA_W-1:0] hold_q;
  logic [NUM_CH-1:0]        fresh_q, fresh_d;
  logic [NUM_CH-1:0]        sent_mask_q;
  logic                     overrun_q, overrun_d;
  logic [FRAME_BITS-1:0]    shreg_q, shreg_d;
  logic [BODY_BITS-1:0]     body_d;
  logic [FRAME_BITS-1:0]    frame_d;
  logic [CNT_W-1:0]         bit_cnt_q;
  logic                     miso_q;
  logic                     frame_done_q;

  logic sck_rise, sck_fall, cs_rise, cs_fall;
  logic snap, abort, done, last_rise, ov_hit;

  // Edge detection runs on the second synchroniser stage against a one-cycle-old copy.
  assign sck_rise = ~sck_prev_q &  sck_sync_q[1];
  assign sck_fall =  sck_prev_q & ~sck_sync_q[1];
  assign cs_rise  = ~cs_prev_q  &  cs_sync_q[1];
  assign cs_fall  =  cs_prev_q  & ~cs_sync_q[1];

  assign snap      = (state_q == ST_IDLE)  && cs_fall;
  assign abort     = (state_q == ST_SHIFT) && cs_rise;
  assign done      = (state_q == ST_DRAIN) && cs_rise;
  assign last_rise = (state_q == ST_SHIFT) && sck_rise && (bit_cnt_q == CNT_W'(FRAME_BITS - 1));

  // A re-strobe of a still-fresh channel is an overrun, except in the snapshot cycle
  // where the pending sample is being consumed by the frame.
  assign ov_hit = (|(ch.ch_valid & fresh_q)) && !snap;

`ifdef SPI_FRAME_CRC_EN
  function automatic logic [7:0] crc8(input logic [BODY_BITS-1:0] d);
    logic [7:0] c;
    c = 8'h00;
    for (int k = BODY_BITS - 1; k >= 0; k--) begin
      if (c[7] ^ d[k]) c = {c[6:0], 1'b0} ^ 8'h07;
      else             c = {c[6:0], 1'b0};
    end
    return c;
  endfunction
`endif

  // Two-flop synchronisers plus edge-detect history for the asynchronous SPI pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync_q <= 2'b00;
      sck_prev_q <= 1'b0;
      cs_sync_q  <= 2'b11;
      cs_prev_q  <= 1'b1;
    end else begin
      sck_sync_q <= {sck_sync_q[0], rpi_sck};
      sck_prev_q <= sck_sync_q[1];
      cs_sync_q  <= {cs_sync_q[0], rpi_cs};
      cs_prev_q  <= cs_sync_q[1];
    end
  end

  // Frame state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state: CS fall starts a frame, last SCK rise drains, CS rise ends or aborts.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cs_fall) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (cs_rise)        state_d = ST_IDLE;
        else if (last_rise) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (cs_rise) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Holding registers always take new samples; the snapshot reads the pre-update value.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch.ch_valid[i]) hold_q[i*DATA_W +: DATA_W] <= ch.ch_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Freshness and sticky overrun bookkeeping; an abort hands the sent channels back.
  always_comb begin
    fresh_d = fresh_q;
    if (snap)  fresh_d = '0;
    if (abort) fresh_d = fresh_d | sent_mask_q;
    fresh_d = fresh_d | ch.ch_valid;

    overrun_d = overrun_q;
    if (done)   overrun_d = 1'b0;
    if (ov_hit) overrun_d = 1'b1;
  end

  // Freshness, overrun and sent-mask registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fresh_q     <= '0;
      overrun_q   <= 1'b0;
      sent_mask_q <= '0;
    end else begin
      fresh_q   <= fresh_d;
      overrun_q <= overrun_d;
      if (snap) sent_mask_q <= fresh_q;
    end
  end

  // Frame image: header {overrun, pad, fresh mask}, then ch0 .. ch(NUM_CH-1), optional CRC.
  always_comb begin
    body_d = '0;
    body_d[BODY_BITS-1]          = overrun_q;
    body_d[BODY_BITS-8 +: NUM_CH] = fresh_q;
    for (int i = 0; i < NUM_CH; i++) begin
      body_d[BODY_BITS-9-i*DATA_W -: DATA_W] = hold_q[i*DATA_W +: DATA_W];
    end
`ifdef SPI_FRAME_CRC_EN
    frame_d = {body_d, crc8(body_d)};
`else
    frame_d = body_d;
`endif
  end

  // Shift register loads at snapshot and advances on each SCK fall while shifting.
  always_comb begin
    shreg_d = shreg_q;
    if (snap) begin
      shreg_d = frame_d;
    end else if ((state_q == ST_SHIFT) && sck_fall) begin
      shreg_d = {shreg_q[FRAME_BITS-2:0], IDLE_BIT};
    end
  end

  // Shift register, rising-edge bit counter and registered MISO driver.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      miso_q    <= IDLE_BIT;
    end else begin
      shreg_q <= shreg_d;
      if (snap)                                     bit_cnt_q <= '0;
      else if ((state_q == ST_SHIFT) && sck_rise)   bit_cnt_q <= bit_cnt_q + 1'b1;
      miso_q <= (state_d == ST_SHIFT) ? shreg_d[FRAME_BITS-1] : IDLE_BIT;
    end
  end

  // Completion pulse, only for frames that reached the drain state.
  always_ff @(posedge clk) begin
    if (rst) frame_done_q <= 1'b0;
    else     frame_done_q <= done;
  end

  assign rpi_miso   = miso_q;
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

endmodule
